// File: rtl/conv_window_gen_pkg.sv
// Shared constants for the sliding-window generator: LeNet-5 conv1 defaults
// and the flattened window element index.
package conv_window_gen_pkg;

    localparam int IMG_ROWS  = 28;
    localparam int IMG_COLS  = 28;
    localparam int C1_KSIZE  = 5;
    localparam int PIXEL_W   = 8;

    function automatic int win_idx(input int r, input int c, input int ksize);
        return r * ksize + c;
    endfunction

endpackage

// File: rtl/conv_window_gen_rowbuffer.sv
// DEPTH-deep enabled shift line; data_o is the sample pushed DEPTH enables ago.
// Contents are intentionally not reset.
module conv_window_gen_rowbuffer #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign data_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-stream KSIZE x KSIZE sliding-window generator for the conv MAC stage.
// Optional macro CONV_WINDOW_GEN_POS_EN adds window top-left coordinate outputs.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int ROWS      = IMG_ROWS,
    parameter int COLS      = IMG_COLS,
    parameter int KSIZE     = C1_KSIZE,
    parameter int BIT_WIDTH = PIXEL_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [BIT_WIDTH-1:0]             in_pixel,
    input  logic                             in_valid,
    output logic [KSIZE*KSIZE*BIT_WIDTH-1:0] window_out,
    output logic                             out_valid,
`ifdef CONV_WINDOW_GEN_POS_EN
    output logic [$clog2(ROWS)-1:0]          out_row,
    output logic [$clog2(COLS)-1:0]          out_col,
`endif
    output logic                             frame_done
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] K_M1_R   = RW'(KSIZE - 1);
    localparam logic [CW-1:0] K_M1_C   = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    logic [RW-1:0]        row_cnt_q, row_cnt_d;
    logic [CW-1:0]        col_cnt_q, col_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic [BIT_WIDTH-1:0] win_q [KSIZE][KSIZE];
    logic [BIT_WIDTH-1:0] win_d [KSIZE][KSIZE];
    logic [BIT_WIDTH-1:0] line_out [KSIZE-1];
    logic [BIT_WIDTH-1:0] col_in [KSIZE];
    logic                 col_wrap, row_wrap;

    for (genvar k = 0; k < KSIZE - 1; k++) begin : g_line
        if (k == 0) begin : g_first
            conv_window_gen_rowbuffer #(.DEPTH(COLS), .WIDTH(BIT_WIDTH)) u_line (
                .clk    (clk),
                .en_i   (in_valid),
                .data_i (in_pixel),
                .data_o (line_out[k])
            );
        end else begin : g_chain
            conv_window_gen_rowbuffer #(.DEPTH(COLS), .WIDTH(BIT_WIDTH)) u_line (
                .clk    (clk),
                .en_i   (in_valid),
                .data_i (line_out[k-1]),
                .data_o (line_out[k])
            );
        end
        // Deeper lines hold older rows, so they feed rows nearer the top.
        assign col_in[KSIZE-2-k] = line_out[k];
    end
    assign col_in[KSIZE-1] = in_pixel;

    assign col_wrap = (col_cnt_q == COL_LAST);
    assign row_wrap = (row_cnt_q == ROW_LAST);

    always_comb begin
        row_cnt_d    = row_cnt_q;
        col_cnt_d    = col_cnt_q;
        win_d        = win_q;
        out_valid_d  = in_valid && (row_cnt_q >= K_M1_R) && (col_cnt_q >= K_M1_C);
        frame_done_d = in_valid && row_wrap && col_wrap;
        if (in_valid) begin
            col_cnt_d = col_wrap ? '0 : col_cnt_q + CW'(1);
            if (col_wrap) begin
                row_cnt_d = row_wrap ? '0 : row_cnt_q + RW'(1);
            end
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KSIZE-1] = col_in[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt_q    <= '0;
            col_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            row_cnt_q    <= row_cnt_d;
            col_cnt_q    <= col_cnt_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    for (genvar r = 0; r < KSIZE; r++) begin : g_row
        for (genvar c = 0; c < KSIZE; c++) begin : g_col
            assign window_out[win_idx(r, c, KSIZE)*BIT_WIDTH +: BIT_WIDTH] = win_q[r][c];
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

`ifdef CONV_WINDOW_GEN_POS_EN
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_row_q <= '0;
            out_col_q <= '0;
        end else if (out_valid_d) begin
            out_row_q <= row_cnt_q - K_M1_R;
            out_col_q <= col_cnt_q - K_M1_C;
        end
    end

    assign out_row = out_row_q;
    assign out_col = out_col_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen (BIT_WIDTH=16, pixel = base + row*COLS + col).
module tb_conv_window_gen;

    localparam int ROWS = 28;
    localparam int COLS = 28;
    localparam int K    = 5;
    localparam int BW   = 16;
    localparam int WW   = K * K * BW;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] in_pixel;
    logic          in_valid;
    logic [WW-1:0] window_out;
    logic          out_valid;
    logic          frame_done;
`ifdef CONV_WINDOW_GEN_POS_EN
    logic [4:0]    out_row;
    logic [4:0]    out_col;
`endif

    conv_window_gen #(.ROWS(ROWS), .COLS(COLS), .KSIZE(K), .BIT_WIDTH(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .window_out (window_out),
        .out_valid  (out_valid),
`ifdef CONV_WINDOW_GEN_POS_EN
        .out_row    (out_row),
        .out_col    (out_col),
`endif
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] win;
        bit            fd;
        int            r0;
        int            c0;
        int            base;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            win_cnt = 0;
    int            fd_total = 0;
    bit            mon_en = 1'b0;
    logic          iv_q = 1'b0;
    logic          rst_q = 1'b0;
    logic [WW-1:0] prev_win;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_win(input logic [WW-1:0] act, input logic [WW-1:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int el(input logic [WW-1:0] w, input int r, input int c);
        return int'(w[(r*K+c)*BW +: BW]);
    endfunction

    function automatic int pix(input int base, input int r, input int c);
        return base + r * COLS + c;
    endfunction

    task automatic beat(input int base, input int r, input int c, input bit gaps);
        exp_t e;
        if (gaps) begin
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                in_valid = 1'b0;
                in_pixel = BW'($urandom);
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_pixel = BW'(pix(base, r, c));
        @(posedge clk);
        if (r >= K - 1 && c >= K - 1) begin
            e.r0   = r - (K - 1);
            e.c0   = c - (K - 1);
            e.base = base;
            e.fd   = (r == ROWS - 1 && c == COLS - 1);
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    e.win[(i*K+j)*BW +: BW] = BW'(pix(base, e.r0 + i, e.c0 + j));
            q.push_back(e);
        end
        #1;
    endtask

    task automatic frame(input int base, input bit gaps, input int stop_r, input int stop_c);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r > stop_r || (r == stop_r && c > stop_c)) return;
                beat(base, r, c, gaps);
            end
        end
    endtask

    always @(posedge clk) begin
        iv_q  <= in_valid;
        rst_q <= rst;
    end

    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (mon_en) begin
            have = (q.size() != 0);
            chk(out_valid == have, "out_valid_strobe", longint'(out_valid), longint'(have));
            if (have) begin
                e = q.pop_front();
                if (out_valid) begin
                    chk_win(window_out, e.win, $sformatf("window(%0d,%0d)", e.r0, e.c0));
                    chk(frame_done == e.fd, "frame_done_on_window", longint'(frame_done), longint'(e.fd));
                    if (e.r0 == 0 && e.c0 == 0) begin
                        chk(el(window_out, 0, 0) == e.base, "first_el00", el(window_out, 0, 0), e.base);
                        chk(el(window_out, 4, 4) == e.base + 116, "first_el44", el(window_out, 4, 4), e.base + 116);
                    end
                    if (e.r0 == 1 && e.c0 == 0)
                        chk(el(window_out, 0, 0) == e.base + 28, "row5_el00", el(window_out, 0, 0), e.base + 28);
                    if (e.r0 == 23 && e.c0 == 23)
                        chk(el(window_out, 4, 4) == e.base + 783, "last_el44", el(window_out, 4, 4), e.base + 783);
`ifdef CONV_WINDOW_GEN_POS_EN
                    chk(int'(out_row) == e.r0, "out_row", out_row, e.r0);
                    chk(int'(out_col) == e.c0, "out_col", out_col, e.c0);
`endif
                    win_cnt++;
                    if (frame_done) begin
                        chk(win_cnt == 576, "windows_per_frame", win_cnt, 576);
                        win_cnt = 0;
                        fd_total++;
                    end
                end
            end else if (!out_valid) begin
                chk(frame_done == 1'b0, "frame_done_idle", longint'(frame_done), 0);
            end
            if (!iv_q && !rst_q)
                chk_win(window_out, prev_win, "window_hold_in_gap");
            if (rst_q)
                win_cnt = 0;
            prev_win = window_out;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(out_valid == 1'b0, "reset_out_valid", longint'(out_valid), 0);
        chk(frame_done == 1'b0, "reset_frame_done", longint'(frame_done), 0);
        chk_win(window_out, '0, "reset_window");
        rst    = 1'b0;
        prev_win = window_out;
        mon_en = 1'b1;

        frame(0, 1'b0, ROWS - 1, COLS - 1);
        frame(1000, 1'b0, ROWS - 1, COLS - 1);
        frame(0, 1'b1, ROWS - 1, COLS - 1);
        frame(3000, 1'b0, 10, 7);

        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk(out_valid == 1'b0, "rst_mid_out_valid", longint'(out_valid), 0);
        chk(frame_done == 1'b0, "rst_mid_frame_done", longint'(frame_done), 0);
        chk_win(window_out, '0, "rst_mid_window");

        frame(0, 1'b0, ROWS - 1, COLS - 1);

        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk(q.size() == 0, "scoreboard_drained", q.size(), 0);
        chk(fd_total == 4, "frames_completed", fd_total, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Sliding-window generator that sits directly downstream of the feature-map pixel source.
- Accepts a raster-order pixel stream (ROWS x COLS, one pixel per in_valid beat).
- Uses a chain of KSIZE-1 COLS-deep row delay lines plus a KSIZE x KSIZE register window.
- Presents every fully-inside KSIZE x KSIZE window to the convolution MAC stage, with a valid strobe.
- Default configuration is LeNet-5 conv1: 28x28 input, 5x5 kernel, 24x24 = 576 windows per frame.

Parameters:
- ROWS, 28, input feature-map height.
- COLS, 28, input feature-map width; also the depth of each row delay line.
- KSIZE, 5, square window edge; must be 2..min(ROWS,COLS).
- BIT_WIDTH, 8, pixel width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_pixel  in  BIT_WIDTH  raster-order pixel.
- in_valid  in  1  in_pixel valid this cycle; all state advances only on in_valid.
- window_out  out  KSIZE*KSIZE*BIT_WIDTH  flattened window. Element (r,c) is at bits [(r*KSIZE+c)*BIT_WIDTH +: BIT_WIDTH]; r=0 is the top (oldest) row, c=0 the left (oldest) column.
- out_valid  out  1  window_out holds a complete in-image window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (clk edge with rst=1):
  - col_cnt=0, row_cnt=0, out_valid=0, frame_done=0, window registers=0.
  - Row delay line contents are don't-care (no reset); validity gating by row_cnt masks stale data.
- Row delay lines:
  - Line 0 input is in_pixel; line k input is the output of line k-1.
  - Every line shifts only when in_valid=1.
  - During beat (row,col), the output of line k equals pixel (row-1-k, col).
- Window registers:
  - On an in_valid beat, each row's register chain shifts left (c decrements), and the new column enters at c=KSIZE-1.
  - Row KSIZE-1 takes in_pixel; row KSIZE-2-k takes the output of line k.
  - Without in_valid, the window holds its value.
- Counters:
  - col_cnt increments on in_valid and wraps COLS-1 -> 0; on that wrap, row_cnt increments.
  - row_cnt wraps ROWS-1 -> 0 at end of frame. The next frame starts immediately; back-to-back frames are allowed with zero gap.
- out_valid:
  - Registered value of (in_valid && row_cnt>=KSIZE-1 && col_cnt>=KSIZE-1), evaluated with pre-increment counter values.
  - Latency is 1 cycle from the completing beat; window_out is valid in the same cycle.
  - Windows never straddle a row wrap: col_cnt<KSIZE-1 suppresses output.
  - Windows never straddle a frame: row_cnt<KSIZE-1 suppresses output, even though the delay lines still hold previous-frame data.
- frame_done:
  - Registered value of (in_valid && row_cnt==ROWS-1 && col_cnt==COLS-1).
  - Coincides with out_valid for the last window.
- Gaps in in_valid: out_valid=0 and window_out holds. There is no backpressure; the consumer must accept every out_valid cycle.
- rst asserted mid-frame: counters clear, out_valid and frame_done go 0 on the next cycle, and the next accepted pixel is treated as (0,0).

Optional Feature:
- Macro CONV_WINDOW_GEN_POS_EN.
- Defined:
  - Adds outputs out_row [$clog2(ROWS)-1:0] and out_col [$clog2(COLS)-1:0].
  - They hold the top-left coordinate of the current window (row_cnt-(KSIZE-1), col_cnt-(KSIZE-1) at the completing beat), registered alongside out_valid. Reset value is 0.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package, constants only:
  - LeNet layer-1 defaults (IMG_ROWS=28, IMG_COLS=28, C1_KSIZE=5, PIXEL_W=8).
  - A localparam function for the flattened window index (r*KSIZE+c).
- Sub-module: the existing rowbuffer (COLS-deep enabled shift line), instantiated KSIZE-1 times in a generate loop.
- Counters, window register array and output logic live in conv_window_gen itself.

Test Plan (BIT_WIDTH=16, pixel value = row*COLS+col, defaults otherwise):
- Continuous frame, in_valid=1 throughout:
  - First out_valid is 1 cycle after beat (4,4), with element(0,0)=0 and element(4,4)=116.
  - Exactly 576 out_valid cycles per frame.
  - frame_done pulses once, 1 cycle after beat (27,27), with element(4,4)=783.
- Random in_valid gaps (about 50% duty):
  - Sequence of windows identical to the continuous case.
  - out_valid is never high in a gap cycle, and window_out is stable during gaps.
- Row boundary: no out_valid after beats (r,0)..(r,3) for any r; the window after beat (5,4) has element(0,0)=28.
- Back-to-back frames (second frame values offset +1000):
  - No out_valid during frame-2 rows 0..3.
  - First frame-2 window has element(0,0)=1000, i.e. no frame-1 data leaks into it.
- rst pulsed after beat (10,7): out_valid and frame_done go 0; the restarted frame's first window appears only after its beat (4,4), with correct values.
- With CONV_WINDOW_GEN_POS_EN: out_row/out_col read (0,0) on the first window and (23,23) on the last.
